io_store_bridge: RTL
====================

IO_STORE_BRIDGE -- requirements
Module: io_store_bridge

Interface
REQ-001: Parameter FIFO_DEPTH, default 4, store-buffer entries; power of two, 2..16.
REQ-002: Parameter IO_BASE, default 32'h0000_2000, byte address of the I/O window; 16-byte aligned.
REQ-003: clock  input  1  single clock; all state updates on its rising edge.
REQ-004: reset  input  1  asynchronous, active-low reset (low = in reset).
REQ-005: cpu_wr_valid  input  1  CPU store request present.
REQ-006: cpu_wr_addr  input  32  store byte address.
REQ-007: cpu_wr_data  input  32  store data; only bits [7:0] are used.
REQ-008: cpu_wr_ready  output  1  bridge can accept a store this cycle.
REQ-009: portd_wr_en  output  1  one-cycle write strobe to the PORTD data register.
REQ-010: ddrd_wr_en  output  1  one-cycle write strobe to the DDRD direction register.
REQ-011: io_wr_data  output  8  data accompanying either strobe.
REQ-012: err_unmapped  output  1  sticky flag: a store hit an unmapped offset.
REQ-013: fifo_level  output  log2(FIFO_DEPTH)+1  number of entries currently buffered.

Function
REQ-014: A store SHALL be accepted on a rising edge where cpu_wr_valid and cpu_wr_ready are both high; cpu_wr_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-015: Decode: addr == IO_BASE+0x0 -> PORTD; addr == IO_BASE+0x4 -> DDRD; any other address -> unmapped.
REQ-016: Unmapped stores SHALL be accepted (ready honoured) but not buffered; err_unmapped SHALL be set the cycle after acceptance and stay set until reset.
REQ-017: Mapped stores SHALL enter the FIFO in acceptance order, storing target (1 bit) and data[7:0].
REQ-018: Drain FSM states: IDLE (FIFO empty, strobes low), ISSUE (head popped, exactly one strobe high for one cycle with io_wr_data = head data), GAP (only when REQ-027 applies).
REQ-019: IDLE -> ISSUE when FIFO non-empty; ISSUE -> ISSUE while entries remain; ISSUE -> IDLE when empty after pop.
REQ-020: Latency: a mapped store accepted into an empty FIFO at edge N SHALL produce its strobe in the cycle following edge N+1; back-to-back accepted stores SHALL produce back-to-back strobes.
REQ-021: portd_wr_en and ddrd_wr_en SHALL never be high in the same cycle; io_wr_data SHALL hold its last value when no strobe is high.
REQ-022: Simultaneous push and pop SHALL be legal when not full; fifo_level unchanged. When full, no push occurs on that edge even if a pop does; ready rises the following cycle.
REQ-023: FIFO pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH or go below 0.

Reset
REQ-024: reset low SHALL immediately (asynchronously) clear FIFO, fifo_level=0, FSM=IDLE, portd_wr_en=0, ddrd_wr_en=0, io_wr_data=8'h00, err_unmapped=0, cpu_wr_ready=0.
REQ-025: Reset asserted mid-drain SHALL discard all buffered stores without issuing further strobes.
REQ-026: cpu_wr_ready SHALL rise in the first cycle after reset deasserts.

Configuration
REQ-027: Macro IO_BRIDGE_PACE_EN: when defined, ISSUE SHALL always go to GAP for exactly one cycle (strobes low) before the next ISSUE or IDLE, so strobes are separated by at least one low cycle; when undefined, GAP is absent and REQ-020 back-to-back timing applies.

Verification
REQ-028: Single store addr 0x2000 data 0xA5 -> portd_wr_en high one cycle, io_wr_data=0xA5, one cycle after acceptance edge; fifo_level returns to 0.
REQ-029: Four stores accepted on consecutive edges to 0x2000/0x2004/0x2000/0x2004 data 0x01..0x04 -> strobes PORTD,DDRD,PORTD,DDRD with data 0x01..0x04 in order on consecutive cycles (with IO_BRIDGE_PACE_EN: every other cycle).
REQ-030: Hold downstream busy by injecting 6 stores in 6 cycles with FIFO_DEPTH=4, PACE enabled -> cpu_wr_ready drops when fifo_level=4, no store lost, all 6 strobes issued in order.
REQ-031: Store to 0x2008 data 0x55 -> accepted, no strobe, err_unmapped=1 next cycle and remains 1 through later valid stores.
REQ-032: Reset low with fifo_level=3 -> strobes and fifo_level 0 immediately, err_unmapped 0, no strobe after release, cpu_wr_ready 1 in first post-reset cycle.

Source files
------------

// File: rtl/io_store_bridge_if.sv
// CPU store handshake plus PORTD/DDRD write strobes and bridge status.
// slave = bridge side, master = CPU/observer side.
interface io_store_bridge_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          cpu_wr_valid;
  logic [31:0]   cpu_wr_addr;
  logic [31:0]   cpu_wr_data;
  logic          cpu_wr_ready;
  logic          portd_wr_en;
  logic          ddrd_wr_en;
  logic [7:0]    io_wr_data;
  logic          err_unmapped;
  logic [LW-1:0] fifo_level;

  modport slave (
    input  cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    output cpu_wr_ready, portd_wr_en, ddrd_wr_en, io_wr_data, err_unmapped, fifo_level
  );

  modport master (
    output cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
    input  cpu_wr_ready, portd_wr_en, ddrd_wr_en, io_wr_data, err_unmapped, fifo_level
  );
endinterface

// File: rtl/io_store_bridge.sv
// Buffers CPU stores to PORTD/DDRD and drains them as one-cycle strobes, one cycle after acceptance.
// Ready drops only when the store buffer is full; IO_BRIDGE_PACE_EN inserts one idle cycle after every strobe.
module io_store_bridge #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = 32'h0000_2000
) (
  input logic              clock,
  input logic              reset,
  io_store_bridge_if.slave bus
);
  localparam int              AW         = $clog2(FIFO_DEPTH);
  localparam int              LW         = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LW-1:0]   FULL_LVL   = LW'(FIFO_DEPTH);
  localparam logic [31:0]     PORTD_ADDR = IO_BASE;
  localparam logic [31:0]     DDRD_ADDR  = IO_BASE + 32'h4;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [FIFO_DEPTH-1:0] r_mem_tgt;
  logic [7:0]            r_mem_dat [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_run;
  logic                  r_err;
  logic                  r_head_tgt;
  logic [7:0]            r_data;

  logic w_ready, w_accept, w_hit_portd, w_hit_ddrd, w_push, w_pop, w_empty;
  logic w_unused_data;

  assign w_unused_data = ^bus.cpu_wr_data[31:8];
  // r_run keeps ready low while in reset and for no longer than that.
  assign w_ready     = r_run && (r_level != FULL_LVL);
  assign w_accept    = bus.cpu_wr_valid && w_ready;
  assign w_hit_portd = (bus.cpu_wr_addr == PORTD_ADDR);
  assign w_hit_ddrd  = (bus.cpu_wr_addr == DDRD_ADDR);
  assign w_push      = w_accept && (w_hit_portd || w_hit_ddrd);
  assign w_empty     = (r_level == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Popping the head is what moves the FSM into ISSUE.
  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
`ifdef IO_BRIDGE_PACE_EN
      S_ISSUE: w_state_nxt = S_GAP;
`endif
      default: begin
        w_pop       = !w_empty;
        w_state_nxt = w_empty ? S_IDLE : S_ISSUE;
      end
    endcase
  end

  always_comb begin
    bus.portd_wr_en = 1'b0;
    bus.ddrd_wr_en  = 1'b0;
    if (r_state == S_ISSUE) begin
      bus.portd_wr_en = !r_head_tgt;
      bus.ddrd_wr_en  = r_head_tgt;
    end
  end

  assign bus.cpu_wr_ready = w_ready;
  assign bus.io_wr_data   = r_data;
  assign bus.err_unmapped = r_err;
  assign bus.fifo_level   = r_level;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_run      <= 1'b0;
      r_err      <= 1'b0;
      r_head_tgt <= 1'b0;
      r_data     <= 8'h00;
    end else begin
      r_run   <= 1'b1;
      r_level <= r_level + LW'(w_push) - LW'(w_pop);
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + AW'(1);
        r_head_tgt <= r_mem_tgt[r_rd_ptr];
        r_data     <= r_mem_dat[r_rd_ptr];
      end
      if (w_accept && !(w_hit_portd || w_hit_ddrd)) r_err <= 1'b1;
    end
  end

  // Entry storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_tgt[r_wr_ptr] <= w_hit_ddrd;
      r_mem_dat[r_wr_ptr] <= bus.cpu_wr_data[7:0];
    end
  end
endmodule
